// File: rtl/qam16_timing_pkg.sv
// Shared timing definitions for the qam_16 strobe supervision logic.
// Holds the monitor FSM encoding and the default strobe period.
package qam16_timing_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StAcquire = 2'd1,
    StLocked  = 2'd2,
    StLost    = 2'd3
  } mon_state_e;

  localparam int unsigned DefaultNominalPeriod = 50_000_000;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous active-low reset and clear.
module sat_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pulse_monitor.sv
// Measures the spacing of a periodic one-cycle strobe, flags early and missing
// strobes, and declares lock after LOCK_COUNT consecutive in-window periods.
module pulse_monitor
  import qam16_timing_pkg::*;
#(
  parameter int unsigned NOMINAL_PERIOD = DefaultNominalPeriod,
  parameter int unsigned TOLERANCE      = 1_000,
  parameter int unsigned LOCK_COUNT     = 4,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned ERR_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse_in,
  input  logic             clear,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             pulse_early,
  output logic             pulse_missing,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned GoodW = $clog2(LOCK_COUNT + 1);
  // cnt value at which the period would overrun the window
  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(NOMINAL_PERIOD + TOLERANCE);
  // cnt below this means P = cnt+1 < NOM-TOL
  localparam logic [CNT_W-1:0] EarlyCnt   = CNT_W'(NOMINAL_PERIOD - TOLERANCE - 1);
  localparam logic [GoodW-1:0] GoodLast   = GoodW'(LOCK_COUNT - 1);

  mon_state_e       state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [CNT_W-1:0] period_d, period_q;
  logic             valid_d, valid_q;
  logic             early_d, early_q;
  logic             missing_d, missing_q;
  logic             locked_d, locked_q;
  logic             good_inc, good_clr, err_inc;
  logic [GoodW-1:0] good_cnt;

  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    period_d  = period_q;
    valid_d   = 1'b0;
    early_d   = 1'b0;
    missing_d = 1'b0;
    good_inc  = 1'b0;
    good_clr  = 1'b0;

    unique case (state_q)
      StIdle, StLost: begin
        if (pulse_in) begin
          state_d = StAcquire;
          cnt_d   = '0;
        end
      end
      StAcquire, StLocked: begin
        if (cnt_q == TimeoutCnt) begin
          // Timeout beats a coincident strobe, which becomes the new reference.
          missing_d = 1'b1;
          good_clr  = 1'b1;
          if (pulse_in) begin
            state_d = StAcquire;
            cnt_d   = '0;
          end else begin
            state_d = StLost;
          end
        end else if (pulse_in) begin
          cnt_d    = '0;
          valid_d  = 1'b1;
          period_d = cnt_q + CNT_W'(1);
          if (cnt_q < EarlyCnt) begin
            early_d  = 1'b1;
            good_clr = 1'b1;
            state_d  = StAcquire;
          end else if (state_q == StAcquire) begin
            good_inc = 1'b1;
            if (good_cnt == GoodLast) state_d = StLocked;
          end
        end
      end
      default: ;
    endcase

    if (clear) begin
      state_d   = StIdle;
      cnt_d     = '0;
      period_d  = '0;
      valid_d   = 1'b0;
      early_d   = 1'b0;
      missing_d = 1'b0;
      good_inc  = 1'b0;
    end

    locked_d = (state_d == StLocked);
    err_inc  = early_d | missing_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      early_q   <= 1'b0;
      missing_q <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      early_q   <= early_d;
      missing_q <= missing_d;
      locked_q  <= locked_d;
    end
  end

  sat_counter #(
    .Width (GoodW)
  ) u_good_cnt (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clr_i   (good_clr | clear),
    .inc_i   (good_inc),
    .count_o (good_cnt)
  );

  sat_counter #(
    .Width (ERR_W)
  ) u_err_cnt (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clr_i   (clear),
    .inc_i   (err_inc),
    .count_o (err_count)
  );

  assign period_out    = period_q;
  assign period_valid  = valid_q;
  assign pulse_early   = early_q;
  assign pulse_missing = missing_q;
  assign locked        = locked_q;

endmodule

// File: tb/tb_pulse_monitor.sv
// Directed and randomized strobe sequences checked cycle by cycle against a
// timestamp-based model of the strobe supervision rules.
module tb_pulse_monitor;

  localparam int Nom       = 20;
  localparam int Tol       = 2;
  localparam int LockCount = 3;
  localparam int CntW      = 8;
  localparam int ErrW      = 2;
  localparam int ErrMax    = (1 << ErrW) - 1;

  logic            clk = 1'b0;
  logic            rst_n, pulse_in, clear;
  logic [CntW-1:0] period_out;
  logic            period_valid, pulse_early, pulse_missing, locked;
  logic [ErrW-1:0] err_count;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: mode 0 idle, 1 tracking a reference strobe, 2 lost.
  int cyc   = 0;
  int ref_t = 0;
  int mode  = 0;
  int good  = 0;
  int err   = 0;
  int exp_per = 0;
  bit lk, exp_pv, exp_early, exp_miss;

  pulse_monitor #(
    .NOMINAL_PERIOD (Nom),
    .TOLERANCE      (Tol),
    .LOCK_COUNT     (LockCount),
    .CNT_W          (CntW),
    .ERR_W          (ErrW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pulse_in      (pulse_in),
    .clear         (clear),
    .period_out    (period_out),
    .period_valid  (period_valid),
    .pulse_early   (pulse_early),
    .pulse_missing (pulse_missing),
    .locked        (locked),
    .err_count     (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic model_edge(input bit p, input bit rst);
    int per;
    exp_pv    = 0;
    exp_early = 0;
    exp_miss  = 0;
    if (rst) begin
      mode = 0; good = 0; lk = 0; err = 0; exp_per = 0;
    end else if (mode != 1) begin
      if (p) begin
        mode  = 1;
        ref_t = cyc;
      end
    end else begin
      per = cyc - ref_t;
      if (per == Nom + Tol + 1) begin
        exp_miss = 1;
        good = 0;
        lk   = 0;
        if (err < ErrMax) err++;
        if (p) ref_t = cyc;
        else mode = 2;
      end else if (p) begin
        exp_pv  = 1;
        exp_per = per;
        ref_t   = cyc;
        if (per < Nom - Tol) begin
          exp_early = 1;
          good = 0;
          lk   = 0;
          if (err < ErrMax) err++;
        end else if (!lk) begin
          good++;
          if (good == LockCount) lk = 1;
        end
      end
    end
    cyc++;
  endtask

  task automatic step(input bit p, input bit clr = 1'b0, input bit rn = 1'b1);
    pulse_in = p;
    clear    = clr;
    rst_n    = rn;
    @(posedge clk);
    model_edge(p, clr || !rn);
    #1;
    chk("period_valid", period_valid, exp_pv);
    chk("period_out", period_out, exp_per);
    chk("pulse_early", pulse_early, exp_early);
    chk("pulse_missing", pulse_missing, exp_miss);
    chk("locked", locked, lk);
    chk("err_count", err_count, err);
  endtask

  // Next strobe g cycles after the previous one.
  task automatic gap(input int g);
    repeat (g - 1) step(1'b0);
    step(1'b1);
  endtask

  initial begin
    pulse_in = 1'b0;
    clear    = 1'b0;
    rst_n    = 1'b0;

    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("reset_locked", locked, 0);
    chk("reset_period", period_out, 0);
    repeat (4) step(1'b0);

    // Steady 20-cycle strobes acquire lock after the fourth strobe.
    step(1'b1);
    chk("t1_first_no_valid", period_valid, 0);
    repeat (3) gap(20);
    chk("t1_locked", locked, 1);
    chk("t1_period", period_out, 20);
    gap(20);
    chk("t1_err", err_count, 0);

    // Early strobe while locked, then relock.
    gap(15);
    chk("t2_early", pulse_early, 1);
    chk("t2_period", period_out, 15);
    chk("t2_unlocked", locked, 0);
    chk("t2_err", err_count, 1);
    repeat (3) gap(20);
    chk("t2_relock", locked, 1);

    // Strobes stop: missing exactly 23 cycles after the last strobe.
    repeat (22) step(1'b0);
    chk("t3_not_yet", pulse_missing, 0);
    step(1'b0);
    chk("t3_missing", pulse_missing, 1);
    chk("t3_unlocked", locked, 0);
    repeat (10) step(1'b0);
    step(1'b1);
    chk("t3_no_valid", period_valid, 0);
    repeat (2) gap(20);
    chk("t3_still_unlocked", locked, 0);

    // Window edges.
    gap(20);
    chk("t4_locked", locked, 1);
    gap(18);
    chk("t4_p18_ok", pulse_early, 0);
    gap(22);
    chk("t4_p22_locked", locked, 1);
    gap(17);
    chk("t4_p17_early", pulse_early, 1);
    gap(23);
    chk("t4_p23_missing", pulse_missing, 1);
    chk("t4_p23_no_valid", period_valid, 0);
    gap(20);
    chk("t4_new_ref", period_out, 20);

    // Error counter saturation and soft clear (clear beats a strobe).
    step(1'b0, 1'b1);
    step(1'b1);
    repeat (5) gap(5);
    chk("t5_err_sat", err_count, 3);
    step(1'b1, 1'b1);
    chk("t5_err_clr", err_count, 0);
    gap(7);
    chk("t5_no_valid", period_valid, 0);

    // Reset mid-period while locked, with pulse_in high during reset.
    repeat (3) gap(20);
    chk("t6_locked", locked, 1);
    repeat (10) step(1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("t6_rst_locked", locked, 0);
    chk("t6_rst_valid", period_valid, 0);
    chk("t6_rst_err", err_count, 0);
    repeat (3) step(1'b0);
    step(1'b1);
    gap(20);
    chk("t6_restart_valid", period_valid, 1);

    // Randomized strobe spacing with occasional clear/reset.
    for (int i = 0; i < 300; i++) begin
      int g;
      g = $urandom_range(1, 30);
      if (g > 12 && g < 17) g = $urandom_range(18, 22);
      if ($urandom_range(0, 59) == 0) step(1'b1, 1'b1);
      if ($urandom_range(0, 89) == 0) step(1'b1, 1'b0, 1'b0);
      gap(g);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
